alu_datapath: RTL and testbench

ALU_DATAPATH -- requirements
Module: alu_datapath

---
 rtl/alu_datapath.sv | 97 +++++++++
 tb/tb_alu_datapath.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_datapath.sv
// Single-cycle ALU with ALU-control decode and PC/branch-target adders; every output is registered, 1-cycle latency.
// No back-pressure: each in_valid cycle is captured; idle cycles hold data and drop out_valid.
module alu_datapath #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [1:0]  aluop,
  input  logic [3:0]  funct,
  input  logic [31:0] pc,
  input  logic [31:0] offset,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        zero,
  output logic [2:0]  gctl,
  output logic [31:0] pc_next,
  output logic [31:0] br_target
);

  logic [2:0]  w_gctl;
  logic [31:0] w_result;
  logic [31:0] w_pc_next;
  logic [31:0] w_br_target;

  logic        r_out_valid;
  logic [31:0] r_result;
  logic        r_zero;
  logic [2:0]  r_gctl;
  logic [31:0] r_pc_next;
  logic [31:0] r_br_target;

  always_comb begin
    w_gctl = 3'b010;
    if (aluop == 2'b01) begin
      w_gctl = 3'b110;
    end else if (aluop[1]) begin
      unique case (funct)
        4'b0010: w_gctl = 3'b110;
        4'b0100: w_gctl = 3'b000;
        4'b0101: w_gctl = 3'b001;
        4'b1010: w_gctl = 3'b111;
        4'b0110: w_gctl = 3'b011;
        4'b0111: w_gctl = 3'b100;
        default: w_gctl = 3'b010;
      endcase
    end
  end

  // slt uses a true signed compare, so an overflowing A-B cannot flip the answer
  always_comb begin
    w_result = 32'd0;
    unique case (w_gctl)
      3'b000:  w_result = op_a & op_b;
      3'b001:  w_result = op_a | op_b;
      3'b010:  w_result = op_a + op_b;
      3'b110:  w_result = op_a - op_b;
      3'b111:  w_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      3'b011:  w_result = op_a << op_b[4:0];
      3'b100:  w_result = op_a >> op_b[4:0];
      default: w_result = 32'd0;
    endcase
  end

  assign w_pc_next   = pc + PC_STEP;
  assign w_br_target = w_pc_next + {offset[29:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_zero      <= 1'b0;
      r_gctl      <= 3'd0;
      r_pc_next   <= 32'd0;
      r_br_target <= 32'd0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result    <= w_result;
        r_zero      <= (w_result == 32'd0);
        r_gctl      <= w_gctl;
        r_pc_next   <= w_pc_next;
        r_br_target <= w_br_target;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign gctl      = r_gctl;
  assign pc_next   = r_pc_next;
  assign br_target = r_br_target;

endmodule

// File: tb/tb_alu_datapath.sv
// Randomized + directed bench for alu_datapath against a behavioural arithmetic model.
module tb_alu_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] op_a, op_b, pc, offset;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic        out_valid, zero;
  logic [31:0] result, pc_next, br_target;
  logic [2:0]  gctl;

  always #5 clk = ~clk;

  alu_datapath #(.PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .op_a(op_a), .op_b(op_b), .aluop(aluop), .funct(funct),
    .pc(pc), .offset(offset),
    .out_valid(out_valid), .result(result), .zero(zero), .gctl(gctl),
    .pc_next(pc_next), .br_target(br_target)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        e_vld;
  logic [31:0] e_res;
  logic        e_zero;
  logic [2:0]  e_gctl;
  logic [31:0] e_pcn, e_bt;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic string op_name(input logic [1:0] ao, input logic [3:0] f);
    if (ao == 2'b00) return "add";
    if (ao == 2'b01) return "sub";
    case (f)
      4'd2:    return "sub";
      4'd4:    return "and";
      4'd5:    return "or";
      4'd10:   return "slt";
      4'd6:    return "sll";
      4'd7:    return "srl";
      default: return "add";
    endcase
  endfunction

  function automatic logic [2:0] op_code(input string n);
    case (n)
      "and":   return 3'b000;
      "or":    return 3'b001;
      "sub":   return 3'b110;
      "slt":   return 3'b111;
      "sll":   return 3'b011;
      "srl":   return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [31:0] op_eval(input string n, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned p2 = 64'd1 << b[4:0];
    case (n)
      "and":   return a & b;
      "or":    return a | b;
      "sub":   return 32'((ua + MOD - ub) % MOD);
      "slt":   return (sa < sb) ? 32'd1 : 32'd0;
      "sll":   return 32'((ua * p2) % MOD);
      "srl":   return 32'(ua / p2);
      default: return 32'((ua + ub) % MOD);
    endcase
  endfunction

  task automatic step(input string tag, input bit r, input bit v, input logic [1:0] ao,
                      input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] o);
    string nm;
    rst = r; in_valid = v; aluop = ao; funct = f;
    op_a = a; op_b = b; pc = p; offset = o;
    @(posedge clk);
    if (r) begin
      e_vld = 0; e_res = 0; e_zero = 0; e_gctl = 0; e_pcn = 0; e_bt = 0;
    end else if (v) begin
      nm     = op_name(ao, f);
      e_vld  = 1;
      e_gctl = op_code(nm);
      e_res  = op_eval(nm, a, b);
      e_zero = (e_res == 0);
      e_pcn  = 32'(({32'd0, p} + 4) % MOD);
      e_bt   = 32'(({32'd0, p} + 4 + {32'd0, o} * 4) % MOD);
    end else begin
      e_vld = 0;
    end
    #1;
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, e_vld});
    chk({tag, " result"},    result,             e_res);
    chk({tag, " zero"},      {31'd0, zero},      {31'd0, e_zero});
    chk({tag, " gctl"},      {29'd0, gctl},      {29'd0, e_gctl});
    chk({tag, " pc_next"},   pc_next,            e_pcn);
    chk({tag, " br_target"}, br_target,          e_bt);
  endtask

  logic [3:0]  fset [8] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd10, 4'd6, 4'd7, 4'd0};
  logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1F};

  initial begin
    rst = 1; in_valid = 0; aluop = 0; funct = 0;
    op_a = 0; op_b = 0; pc = 0; offset = 0;

    step("reset", 1, 0, 2'b00, 4'd0, 0, 0, 0, 0);

    step("add7p5", 0, 1, 2'b10, 4'b0000, 32'd7, 32'd5, 32'h100, 32'd3);
    chk("add7p5 lit res", result, 32'd12);
    chk("add7p5 lit gctl", {29'd0, gctl}, 32'd2);

    step("sub_eq", 0, 1, 2'b01, 4'b1111, 32'h1234, 32'h1234, 32'h0, 32'h0);
    chk("sub_eq lit zero", {31'd0, zero}, 32'd1);
    chk("sub_eq lit gctl", {29'd0, gctl}, 32'd6);

    step("slt_neg", 0, 1, 2'b10, 4'b1010, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    chk("slt_neg lit res", result, 32'd1);
    step("slt_ovf", 0, 1, 2'b10, 4'b1010, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0);
    chk("slt_ovf lit res", result, 32'd0);

    step("sll", 0, 1, 2'b10, 4'b0110, 32'd3, 32'd4, 32'h0, 32'h0);
    chk("sll lit res", result, 32'd48);
    step("srl", 0, 1, 2'b10, 4'b0111, 32'h80000000, 32'd31, 32'h0, 32'h0);
    chk("srl lit res", result, 32'd1);

    step("br_back", 0, 1, 2'b00, 4'd0, 32'd1, 32'd1, 32'h10, 32'hFFFFFFFE);
    chk("br_back lit pcn", pc_next, 32'h14);
    chk("br_back lit bt", br_target, 32'hC);
    step("pc_wrap", 0, 1, 2'b00, 4'd0, 32'd1, 32'd1, 32'hFFFFFFFC, 32'h0);
    chk("pc_wrap lit pcn", pc_next, 32'h0);
    step("off_hi", 0, 1, 2'b00, 4'd0, 32'd0, 32'd0, 32'h40, 32'hC0000001);

    step("hold", 0, 0, 2'b01, 4'd0, 32'd9, 32'd1, 32'h88, 32'h5);

    step("rst_drop", 1, 1, 2'b10, 4'b0000, 32'd7, 32'd5, 32'h10, 32'h1);
    chk("rst_drop lit res", result, 32'd0);
    step("post_rst", 0, 0, 2'b10, 4'b0000, 32'd7, 32'd5, 32'h10, 32'h1);
    chk("post_rst lit vld", {31'd0, out_valid}, 32'd0);
    chk("post_rst lit pcn", pc_next, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      step($sformatf("rnd%0d", i), $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0) ? 4'($urandom) : fset[$urandom_range(0, 7)],
           a, b, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
